// File: rtl/shift_pkg.sv
// Shared definitions for the shift command queue: command record layout,
// direction/mode encodings and default sizing.
package shift_pkg;

  localparam int DATA_W        = 8;
  localparam int AMT_W         = 3;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_TAG_W = 4;

  localparam logic DIR_RIGHT    = 1'b0;
  localparam logic DIR_LEFT     = 1'b1;
  localparam logic MODE_LOGICAL = 1'b0;
  localparam logic MODE_ARITH   = 1'b1;

  // Tag is kept in a parallel array so its width can follow TAG_W.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
    logic              dir;
    logic              arith;
  } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter_8bit.sv
// Combinational 8-bit shifter: left zero-fill, right logical or arithmetic.
module barrel_shifter_8bit
  import shift_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] amount,
  input  logic       dir,
  input  logic       arith,
  output logic [7:0] result
);

  always_comb begin
    result = data;
    if (dir == DIR_LEFT) begin
      result = data << amount;
    end else if (arith == MODE_ARITH) begin
      result = 8'($signed(data) >>> amount);
    end else begin
      result = data >> amount;
    end
  end

endmodule

// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding a barrel shifter into a registered, tagged result stage.
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [2:0]               in_amount,
  input  logic                     in_dir,
  input  logic                     in_arith,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both 1; valid never depends on ready, and in_ready depends only on count.
  shift_cmd_t       cmd_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic             push;
  logic             pop;
  shift_cmd_t       head;
  shift_cmd_t       in_cmd;
  logic [7:0]       shifted;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid || out_ready);
  assign head     = cmd_mem[rd_ptr];

  always_comb begin
    in_cmd        = '0;
    in_cmd.data   = in_data;
    in_cmd.amount = in_amount;
    in_cmd.dir    = in_dir;
    in_cmd.arith  = in_arith;
  end

  barrel_shifter_8bit u_shifter (
    .data   (head.data),
    .amount (head.amount),
    .dir    (head.dir),
    .arith  (head.arith),
    .result (shifted)
  );

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr] <= in_cmd;
      tag_mem[wr_ptr] <= tag_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= shifted;
      out_tag   <= tag_mem[rd_ptr];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scenario-based bench for shift_cmd_queue with an expected-result queue
// checked against every consumed output.
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [2:0]       in_amount;
  logic             in_dir;
  logic             in_arith;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       count;

  logic [TAG_W+7:0] exp_q[$];
  logic [TAG_W-1:0] tb_tag;
  int               vectors;
  int               miscompares;

  shift_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tb_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_shift(input logic [7:0] d, input int amt,
                                             input logic dir, input logic arith);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int src;
      if (dir) begin
        src = i - amt;
        r[i] = (src >= 0) ? d[src] : 1'b0;
      end else begin
        src = i + amt;
        r[i] = (src < 8) ? d[src] : (arith ? d[7] : 1'b0);
      end
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge
  // with in_valid still high so back-to-back calls stream without gaps.
  task automatic drive_cmd(input logic [7:0] d, input logic [2:0] a,
                           input logic dir, input logic ar);
    bit got;
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_dir    = dir;
    in_arith  = ar;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else @(posedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end else begin
      exp_q.push_back({tb_tag, model_shift(d, int'(a), dir, ar)});
      tb_tag++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got tag %0d data 0x%02h, required no output", out_tag, out_data);
      end else begin
        logic [TAG_W+7:0] e;
        e = exp_q.pop_front();
        if ({out_tag, out_data} !== e) begin
          miscompares++;
          $display("FAIL sb_result: got tag %0d data 0x%02h, required tag %0d data 0x%02h",
                   out_tag, out_data, e[TAG_W+7:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({out_valid, count, in_ready, out_data, out_tag} !== {1'b0, 3'd0, 1'b1, 8'h00, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%0b cnt=%0d rdy=%0b data=0x%02h tag=%0d, required v=0 cnt=0 rdy=1 data=0x00 tag=0",
               out_valid, count, in_ready, out_data, out_tag);
    end
    apply_reset();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_cmd(8'h96, 3'd2, 1'b0, 1'b1);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL latency_first_edge: got v=%0b cnt=%0d, required v=0 cnt=1", out_valid, count);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hE5 || out_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL latency_result: got v=%0b data=0x%02h tag=%0d, required v=1 data=0xE5 tag=0",
               out_valid, out_data, out_tag);
    end
    wait_drain();
  endtask

  task automatic test_modes();
    logic [7:0] exp_tab [3];
    logic [2:0] amt_tab [3];
    logic       dir_tab [3];
    logic       ar_tab  [3];
    exp_tab = '{8'hB0, 8'h01, 8'h2C};
    amt_tab = '{3'd3, 3'd7, 3'd1};
    dir_tab = '{1'b1, 1'b0, 1'b1};
    ar_tab  = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(8'h96, amt_tab[i], dir_tab[i], ar_tab[i]);
      in_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL mode_%0d: got v=%0b data=0x%02h, required v=1 data=0x%02h",
                 i, out_valid, out_data, exp_tab[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_full();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data   = 8'($urandom_range(0, 255));
      in_amount = 3'($urandom_range(0, 7));
      in_dir    = 1'($urandom_range(0, 1));
      in_arith  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && exp_q.size() != 0) begin
        vectors++;
        if (out_data !== exp_q[0][7:0]) begin
          miscompares++;
          $display("FAIL full_hold: got data 0x%02h, required 0x%02h", out_data, exp_q[0][7:0]);
        end
      end
      if (in_ready) begin
        exp_q.push_back({tb_tag, model_shift(in_data, int'(in_amount), in_dir, in_arith)});
        tb_tag++;
        accepted++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (accepted != DEPTH + 1 || in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_state: got acc=%0d rdy=%0b cnt=%0d v=%0b, required acc=5 rdy=0 cnt=4 v=1",
               accepted, in_ready, count, out_valid);
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          drive_cmd(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 17; i++) begin
          vectors++;
          if (out_valid !== 1'b1 || out_tag !== TAG_W'(i)) begin
            miscompares++;
            $display("FAIL b2b_stream_%0d: got v=%0b tag=%0d, required v=1 tag=%0d",
                     i, out_valid, out_tag, i % 16);
          end
          @(negedge clk);
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd3 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got cnt=%0d v=%0b, required cnt=3 v=1", count, out_valid);
    end
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    tb_tag = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got v=%0b cnt=%0d rdy=%0b, required v=0 cnt=0 rdy=1",
               out_valid, count, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_cmd(8'h5A, 3'd1, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_data !== 8'hB4) begin
      miscompares++;
      $display("FAIL post_reset_tag: got v=%0b tag=%0d data=0x%02h, required v=1 tag=0 data=0xB4",
               out_valid, out_tag, out_data);
    end
    wait_drain();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tb_tag      = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_amount   = '0;
    in_dir      = 1'b0;
    in_arith    = 1'b0;
    out_ready   = 1'b0;
    rst_n       = 1'b1;
    test_reset();
    test_latency();
    test_modes();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
